// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath control FSM and its instruction decoder.
// Opcode/op fields, ALU operation codes and write-back source codes live here.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_OPERATE   = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOVI    = 3'd0,
    CLS_MOVR    = 3'd1,
    CLS_ALU2    = 3'd2,
    CLS_CMP     = 3'd3,
    CLS_MVN     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field meaning depends on the opcode group
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic VSEL_C   = 1'b0;
  localparam logic VSEL_IMM = 1'b1;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into register selects,
// shift amount, sign-extended immediate, instruction class and ALU operation.
module instr_decode
  import datapath_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir,
  output logic [2:0]       rn,
  output logic [2:0]       rd,
  output logic [2:0]       rm,
  output logic [1:0]       sh,
  output logic [WIDTH-1:0] sximm8,
  output instr_class_t     cls,
  output logic [1:0]       alu_op
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  // Upper bits replicate IR[7]
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sext
      if (gi < 8) begin : g_low
        assign sximm8[gi] = ir[gi];
      end else begin : g_high
        assign sximm8[gi] = ir[7];
      end
    end
  endgenerate

  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OPC_MOV: begin
        case (op)
          OP_MOVI: cls = CLS_MOVI;
          OP_MOVR: cls = CLS_MOVR;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OPC_ALU: begin
        case (op)
          OP_ADD: begin
            cls    = CLS_ALU2;
            alu_op = ALU_ADD;
          end
          OP_CMP: begin
            cls    = CLS_CMP;
            alu_op = ALU_SUB;
          end
          OP_AND: begin
            cls    = CLS_ALU2;
            alu_op = ALU_AND;
          end
          OP_MVN: begin
            cls    = CLS_MVN;
            alu_op = ALU_NOTB;
          end
          default: cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle control FSM for the register-file/ALU datapath: holds the IR and
// issues the read, operand-load, ALU, status and write-back strobes per instruction.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             s,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             vsel,
  output logic [WIDTH-1:0] sximm8,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ir_reg;

  logic [2:0]   rn, rd, rm;
  logic [1:0]   sh;
  logic [1:0]   alu_op;
  instr_class_t cls;

  instr_decode #(.WIDTH(WIDTH)) u_decode (
    .ir     (ir_reg),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (sximm8),
    .cls    (cls),
    .alu_op (alu_op)
  );

  assign shift = sh;
  assign bsel  = 1'b0;

  // IR only accepts a new word while idle, so a load during execution is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_WAIT;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (load && (state_reg == S_WAIT)) begin
        ir_reg <= in;
      end
    end
  end

  always_comb begin
    state_next = S_WAIT;
    case (state_reg)
      S_WAIT:      state_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (cls)
          CLS_MOVI:          state_next = S_WRITE_IMM;
          CLS_MOVR, CLS_MVN: state_next = S_GET_B;
          CLS_ALU2, CLS_CMP: state_next = S_GET_A;
          default:           state_next = S_WAIT;
        endcase
      end
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_OPERATE;
      S_OPERATE:   state_next = (cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
      S_WRITE_IMM: state_next = S_WAIT;
      default:     state_next = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = VSEL_C;
    ALUop    = ALU_ADD;
    case (state_reg)
      S_WAIT: w = 1'b1;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_OPERATE: begin
        // CMP only updates status; everything else lands in C
        loads = (cls == CLS_CMP);
        loadc = (cls != CLS_CMP);
        asel  = (cls == CLS_MOVR) || (cls == CLS_MVN);
        ALUop = alu_op;
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
        vsel     = VSEL_C;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        write    = 1'b1;
        vsel     = VSEL_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: a vector table of per-instruction outcomes,
// hand-written reset/restart sequences, and randomized instructions against a step model.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic [15:0] in_w = '0;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8;
  logic [1:0]  shift, ALUop;

  always #5 clk = ~clk;

  datapath_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in_w), .s(s),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .sximm8(sximm8),
    .shift(shift), .ALUop(ALUop)
  );

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
  } out_t;

  out_t dut_o;
  assign dut_o = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, shift, ALUop, sximm8};

  typedef struct {
    logic [15:0] instr;
    int busy, writes, wn, vsel, loada, loads, alu, asel;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk_o(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs that follow the IR regardless of state
  function automatic out_t idle_o(input logic [15:0] ir);
    out_t o;
    o = '0;
    o.shift  = ir[4:3];
    o.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return o;
  endfunction

  // Action list per instruction: decode, then reads, operate, write-back
  function automatic int build_seq(input logic [15:0] ir, output out_t seq[6]);
    out_t b, ga, gb, op, wr;
    logic [2:0] opc;
    logic [1:0] opf;
    bit movi, movr, alu, mvn, cmp;
    opc  = ir[15:13];
    opf  = ir[12:11];
    movi = (opc == 3'b110) && (opf == 2'b10);
    movr = (opc == 3'b110) && (opf == 2'b00);
    alu  = (opc == 3'b101);
    mvn  = alu && (opf == 2'b11);
    cmp  = alu && (opf == 2'b01);
    b  = idle_o(ir);
    for (int i = 0; i < 6; i++) seq[i] = b;
    ga = b; ga.readnum = ir[10:8]; ga.loada = 1'b1;
    gb = b; gb.readnum = ir[2:0];  gb.loadb = 1'b1;
    op = b; op.asel = movr || mvn; op.ALUop = movr ? 2'b00 : opf;
    if (cmp) op.loads = 1'b1; else op.loadc = 1'b1;
    wr = b; wr.write = 1'b1; wr.writenum = ir[7:5];
    if (movi) begin
      wr.writenum = ir[10:8];
      wr.vsel     = 1'b1;
      seq[1] = wr;
      return 2;
    end else if (movr || mvn) begin
      seq[1] = gb; seq[2] = op; seq[3] = wr;
      return 4;
    end else if (alu) begin
      seq[1] = ga; seq[2] = gb; seq[3] = op;
      if (cmp) return 4;
      seq[4] = wr;
      return 5;
    end
    return 1;
  endfunction

  // Call while idle, just after a falling edge
  task automatic run_model(input logic [15:0] ir, input bit disturb);
    out_t seq[6];
    out_t wt;
    int n;
    n = build_seq(ir, seq);
    in_w = ir; load = 1'b1; s = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (disturb) begin
        s    = 1'($urandom_range(0, 1));
        load = 1'($urandom_range(0, 1));
        in_w = 16'($urandom);
      end else begin
        s = 1'b0; load = 1'b0;
      end
      @(negedge clk);
      chk_o($sformatf("model %h cyc%0d", ir, i), dut_o, seq[i]);
    end
    @(posedge clk); #1;
    s = 1'b0; load = 1'b0;
    wt = idle_o(ir);
    wt.w = 1'b1;
    @(negedge clk);
    chk_o($sformatf("model %h wait", ir), dut_o, wt);
    $display("txn model instr=%h busy=%0d disturb=%0d", ir, n, disturb);
  endtask

  task automatic run_vec(input vec_t v);
    int busy, writes, wn, vs, alu, as, la, ls;
    bit done;
    busy = 0; writes = 0; wn = -1; vs = -1; alu = -1; as = -1; la = 0; ls = 0;
    done = 1'b0;
    in_w = v.instr; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (w) done = 1'b1;
      else begin
        busy++;
        if (write) begin writes++; wn = writenum; vs = vsel; end
        if (loadc || loads) begin alu = ALUop; as = asel; end
        la += loada;
        ls += loads;
      end
    end
    chk_v($sformatf("vec %h returned", v.instr), done, 1);
    chk_v($sformatf("vec %h busy", v.instr), busy, v.busy);
    chk_v($sformatf("vec %h writes", v.instr), writes, v.writes);
    chk_v($sformatf("vec %h loada", v.instr), la, v.loada);
    chk_v($sformatf("vec %h loads", v.instr), ls, v.loads);
    if (v.writes != 0) begin
      chk_v($sformatf("vec %h writenum", v.instr), wn, v.wn);
      chk_v($sformatf("vec %h vsel", v.instr), vs, v.vsel);
    end
    chk_v($sformatf("vec %h aluop", v.instr), alu, v.alu);
    if (v.alu >= 0) chk_v($sformatf("vec %h asel", v.instr), as, v.asel);
    $display("txn vec instr=%h busy=%0d writes=%0d wn=%0d alu=%0d", v.instr, busy, writes, wn, alu);
  endtask

  vec_t vecs[9];
  out_t rst_exp;
  logic [2:0] ropc;

  initial begin
    //          instr     busy wr wn vs la ls alu asel
    vecs[0] = '{16'hD3FB, 2, 1, 3, 1, 0, 0, -1, 0};
    vecs[1] = '{16'hA148, 5, 1, 2, 0, 1, 0,  0, 0};
    vecs[2] = '{16'hA900, 4, 0, 0, 0, 1, 1,  1, 0};
    vecs[3] = '{16'hB887, 4, 1, 4, 0, 0, 0,  3, 1};
    vecs[4] = '{16'hC800, 1, 0, 0, 0, 0, 0, -1, 0};
    vecs[5] = '{16'hB2A1, 5, 1, 5, 0, 1, 0,  2, 0};
    vecs[6] = '{16'hC076, 4, 1, 3, 0, 0, 0,  0, 1};
    vecs[7] = '{16'hE000, 1, 0, 0, 0, 0, 0, -1, 0};
    vecs[8] = '{16'hD800, 1, 0, 0, 0, 0, 0, -1, 0};

    rst_exp = '0;
    rst_exp.w = 1'b1;

    // Reset and idle hold
    repeat (2) @(negedge clk);
    chk_o("reset state", dut_o, rst_exp);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_o("idle hold", dut_o, rst_exp);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Test-plan instructions against the step model, inputs quiet while busy
    run_model(16'hD3FB, 1'b0);
    run_model(16'hA148, 1'b0);
    run_model(16'hA900, 1'b0);
    run_model(16'hB887, 1'b0);
    run_model(16'hC800, 1'b0);

    // s held high restarts on the edge after returning to WAIT
    in_w = 16'hD3FB; load = 1'b1; s = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    @(negedge clk); chk_v("hold-s decode w", w, 0);
    @(negedge clk); chk_v("hold-s write", write, 1);
    @(negedge clk); chk_v("hold-s wait w", w, 1);
    @(posedge clk); #1; s = 1'b0;
    @(negedge clk); chk_v("hold-s restart w", w, 0);
    @(negedge clk); chk_v("hold-s rewrite", write, 1);
    @(negedge clk); chk_v("hold-s done w", w, 1);
    $display("txn hold-s instr=D3FB");

    // Reset asserted mid-GET_B aborts without a write
    in_w = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk); #1; load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); chk_v("abort in GET_B", loadb, 1);
    #2 rst_n = 1'b0;
    #1 chk_o("abort async", dut_o, rst_exp);
    repeat (2) begin
      @(negedge clk);
      chk_o("abort hold", dut_o, rst_exp);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_o("abort release", dut_o, rst_exp);
    end
    $display("txn abort instr=A148");

    // Randomized instructions with noisy load/in/s while busy
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0:       ropc = 3'b110;
        1:       ropc = 3'b101;
        default: ropc = 3'($urandom_range(0, 7));
      endcase
      run_model({ropc, 13'($urandom)}, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
